// File: rtl/ram_loader_if.sv
// Byte-wide valid/ready stream feeding the RAM loader (e.g. from a UART receiver).
interface ram_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/ram_loader.sv
// Parses TARGET/LEN/payload/CHK frames from a byte stream and writes little-endian
// 32-bit words into the instruction or data RAM, then verifies an XOR checksum.
module ram_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  ram_loader_if.slave           in_bus,
  output logic                  fetch_ram_load,
  output logic                  mem_ram_load,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;

  localparam logic [7:0]  TGT_INSTR = 8'h49;
  localparam logic [7:0]  TGT_DATA  = 8'h44;
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

  logic [2:0]            state_r;
  logic [7:0]            len_lo_r;
  logic [16:0]           remaining_r;
  logic [1:0]            byte_idx_r;
  logic [ADDR_WIDTH-1:0] addr_cnt_r;
  logic [7:0]            chk_r;
  logic [23:0]           word_r;
  logic                  in_ready_r;
  logic                  fetch_load_r;
  logic                  mem_load_r;
  logic                  busy_r;
  logic                  ram_we_r;
  logic [ADDR_WIDTH-1:0] ram_addr_r;
  logic [31:0]           ram_wdata_r;
  logic                  done_r;
  logic                  error_r;

  logic                  xfer_s;
  logic [15:0]           len_s;

  assign xfer_s = in_bus.in_valid & in_ready_r;
  assign len_s  = {in_bus.in_data, len_lo_r};

  assign in_bus.in_ready = in_ready_r;
  assign fetch_ram_load  = fetch_load_r;
  assign mem_ram_load    = mem_load_r;
  assign busy            = busy_r;
  assign ram_we          = ram_we_r;
  assign ram_addr        = ram_addr_r;
  assign ram_wdata       = ram_wdata_r;
  assign done            = done_r;
  assign error           = error_r;

  // Frame parser: state, word assembly, checksum and all registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= S_IDLE;
      len_lo_r     <= 8'h00;
      remaining_r  <= 17'd0;
      byte_idx_r   <= 2'd0;
      addr_cnt_r   <= '0;
      chk_r        <= 8'h00;
      word_r       <= 24'h000000;
      in_ready_r   <= 1'b1;
      fetch_load_r <= 1'b0;
      mem_load_r   <= 1'b0;
      busy_r       <= 1'b0;
      ram_we_r     <= 1'b0;
      ram_addr_r   <= '0;
      ram_wdata_r  <= 32'h00000000;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      in_ready_r <= 1'b1;
      ram_we_r   <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      if (xfer_s) begin
        case (state_r)
          S_IDLE: begin
            // Every frame starts from a clean address, lane and checksum.
            addr_cnt_r <= '0;
            byte_idx_r <= 2'd0;
            chk_r      <= 8'h00;
            word_r     <= 24'h000000;
            if (in_bus.in_data == TGT_INSTR) begin
              fetch_load_r <= 1'b1;
              busy_r       <= 1'b1;
              state_r      <= S_LEN_LO;
            end else if (in_bus.in_data == TGT_DATA) begin
              mem_load_r <= 1'b1;
              busy_r     <= 1'b1;
              state_r    <= S_LEN_LO;
            end else begin
              error_r <= 1'b1;
            end
          end
          S_LEN_LO: begin
            len_lo_r <= in_bus.in_data;
            state_r  <= S_LEN_HI;
          end
          S_LEN_HI: begin
            if ({1'b0, len_s} > MAX_WORDS) begin
              error_r      <= 1'b1;
              fetch_load_r <= 1'b0;
              mem_load_r   <= 1'b0;
              busy_r       <= 1'b0;
              state_r      <= S_IDLE;
            end else if (len_s == 16'd0) begin
              state_r <= S_CHECK;
            end else begin
              remaining_r <= {1'b0, len_s};
              state_r     <= S_DATA;
            end
          end
          S_DATA: begin
            chk_r      <= chk_r ^ in_bus.in_data;
            byte_idx_r <= byte_idx_r + 2'd1;
            case (byte_idx_r)
              2'd0: word_r[7:0]   <= in_bus.in_data;
              2'd1: word_r[15:8]  <= in_bus.in_data;
              2'd2: word_r[23:16] <= in_bus.in_data;
              2'd3: begin
                ram_we_r    <= 1'b1;
                ram_addr_r  <= addr_cnt_r;
                ram_wdata_r <= {in_bus.in_data, word_r};
                addr_cnt_r  <= addr_cnt_r + 1'b1;
                remaining_r <= remaining_r - 17'd1;
                if (remaining_r == 17'd1) begin
                  state_r <= S_CHECK;
                end else begin
                  state_r <= S_DATA;
                end
              end
              default: byte_idx_r <= 2'd0;
            endcase
          end
          S_CHECK: begin
            done_r       <= (in_bus.in_data == chk_r);
            error_r      <= (in_bus.in_data != chk_r);
            fetch_load_r <= 1'b0;
            mem_load_r   <= 1'b0;
            busy_r       <= 1'b0;
            state_r      <= S_IDLE;
          end
          default: begin
            fetch_load_r <= 1'b0;
            mem_load_r   <= 1'b0;
            busy_r       <= 1'b0;
            state_r      <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
